// File: rtl/vend_payout_ctrl.sv
// vend_payout_ctrl: drives the product-release motor and the coin hopper on
// behalf of the coin-accepting vending FSM. Each actuation ends when its drop
// sensor pulses, or after TIMEOUT_CYCLES cycles as a jam fault. The block also
// keeps product/coin inventory counters and raises sold-out, change-empty and
// jam flags.
//
// Optional build feature: define PAYOUT_STATS_EN to add the lifetime counters
// vend_total / coin_total (saturating 16-bit, cleared only by rst_n).
module vend_payout_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dispense,
    input  logic             return_req,
    input  logic             prod_sensor,
    input  logic             coin_sensor,
    input  logic             restock,
    input  logic [CNT_W-1:0] restock_prod,
    input  logic [CNT_W-1:0] restock_coin,
    input  logic             fault_clr,
    output logic             motor_on,
    output logic             hopper_on,
    output logic             busy,
    output logic             done,
    output logic             fault_jam,
    output logic             sold_out,
    output logic             change_empty,
    output logic [CNT_W-1:0] prod_count,
    output logic [CNT_W-1:0] coin_count
`ifdef PAYOUT_STATS_EN
    ,
    output logic [15:0]      vend_total,
    output logic [15:0]      coin_total
`endif
);

    // Timer only has to count up to TIMEOUT_CYCLES-1.
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_VEND  = 3'd1,
        S_PAY   = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t           state_q,  state_d;
    logic             pv_q,     pv_d;
    logic             pr_q,     pr_d;
    logic [TMR_W-1:0] tmr_q,    tmr_d;
    logic [CNT_W-1:0] prod_q,   prod_d;
    logic [CNT_W-1:0] coin_q,   coin_d;
    logic             motor_q,  motor_d;
    logic             hopper_q, hopper_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             jam_q,    jam_d;

    logic             clr_pv;
    logic             clr_pr;
    logic             prod_dec;
    logic             coin_dec;
    logic             tmr_last;
    logic             req_accept;

    assign tmr_last = (tmr_q == TMR_LAST);

    // Next-state, pending-flag, timer and registered-output decode.
    always_comb begin
        state_d  = state_q;
        clr_pv   = 1'b0;
        clr_pr   = 1'b0;
        prod_dec = 1'b0;
        coin_dec = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Vend has priority over change; requests that cannot be
                // served are dropped without touching an actuator.
                if (pv_q && (prod_q != '0)) begin
                    state_d = S_VEND;
                end else if (pr_q && (coin_q != '0)) begin
                    state_d = S_PAY;
                end
                if (pv_q && (prod_q == '0)) clr_pv = 1'b1;
                if (pr_q && (coin_q == '0)) clr_pr = 1'b1;
            end
            S_VEND: begin
                if (prod_sensor) begin
                    clr_pv   = 1'b1;
                    prod_dec = 1'b1;
                    state_d  = (pr_q && (coin_q != '0)) ? S_PAY : S_DONE;
                end else if (tmr_last) begin
                    state_d = S_FAULT;
                end
            end
            S_PAY: begin
                if (coin_sensor) begin
                    clr_pr   = 1'b1;
                    coin_dec = 1'b1;
                    state_d  = S_DONE;
                end else if (tmr_last) begin
                    state_d = S_FAULT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (fault_clr) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Requests are dropped while in FAULT and flushed on the way into it.
        // A new request on the same edge as a clear re-arms the flag.
        req_accept = (state_q != S_FAULT) && (state_d != S_FAULT);
        pv_d = req_accept && (dispense   || (pv_q && !clr_pv));
        pr_d = req_accept && (return_req || (pr_q && !clr_pr));

        // Timer restarts on every state change and runs only while actuating.
        if (state_d != state_q) begin
            tmr_d = '0;
        end else if ((state_q == S_VEND) || (state_q == S_PAY)) begin
            tmr_d = tmr_q + TMR_W'(1);
        end else begin
            tmr_d = '0;
        end

        motor_d  = (state_d == S_VEND);
        hopper_d = (state_d == S_PAY);
        done_d   = (state_d == S_DONE);
        busy_d   = (state_d != S_IDLE);
        jam_d    = (state_d == S_FAULT);
    end

    // Inventory: restock overrides a same-cycle decrement; no wrap below zero.
    always_comb begin
        prod_d = prod_q;
        coin_d = coin_q;
        if (restock) begin
            prod_d = restock_prod;
            coin_d = restock_coin;
        end else begin
            if (prod_dec && (prod_q != '0)) prod_d = prod_q - CNT_W'(1);
            if (coin_dec && (coin_q != '0)) coin_d = coin_q - CNT_W'(1);
        end
    end

    // Controller state and registered actuator/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pv_q     <= 1'b0;
            pr_q     <= 1'b0;
            tmr_q    <= '0;
            motor_q  <= 1'b0;
            hopper_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            jam_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pv_q     <= pv_d;
            pr_q     <= pr_d;
            tmr_q    <= tmr_d;
            motor_q  <= motor_d;
            hopper_q <= hopper_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            jam_q    <= jam_d;
        end
    end

    // Inventory counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            coin_q <= '0;
        end else begin
            prod_q <= prod_d;
            coin_q <= coin_d;
        end
    end

`ifdef PAYOUT_STATS_EN
    logic [15:0] vend_total_q, vend_total_d;
    logic [15:0] coin_total_q, coin_total_d;

    // Lifetime counters step on every sensed drop and hold at all-ones.
    always_comb begin
        vend_total_d = vend_total_q;
        coin_total_d = coin_total_q;
        if (prod_dec && (vend_total_q != 16'hFFFF)) vend_total_d = vend_total_q + 16'd1;
        if (coin_dec && (coin_total_q != 16'hFFFF)) coin_total_d = coin_total_q + 16'd1;
    end

    // Lifetime counter registers; restock deliberately leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vend_total_q <= '0;
            coin_total_q <= '0;
        end else begin
            vend_total_q <= vend_total_d;
            coin_total_q <= coin_total_d;
        end
    end

    assign vend_total = vend_total_q;
    assign coin_total = coin_total_q;
`else
    // Lifetime counters are not built in this configuration.
`endif

    assign motor_on     = motor_q;
    assign hopper_on    = hopper_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign fault_jam    = jam_q;
    assign prod_count   = prod_q;
    assign coin_count   = coin_q;
    assign sold_out     = (prod_q == '0);
    assign change_empty = (coin_q == '0);

endmodule

// File: tb/tb_vend_payout_ctrl.sv
// Testbench for vend_payout_ctrl with a short timeout. Expected inventory after
// each transaction is queued when the request is driven and checked on done.
module tb_vend_payout_ctrl;

    localparam int CNT_W = 8;
    localparam int TO    = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             dispense = 1'b0;
    logic             return_req = 1'b0;
    logic             prod_sensor = 1'b0;
    logic             coin_sensor = 1'b0;
    logic             restock = 1'b0;
    logic [CNT_W-1:0] restock_prod = '0;
    logic [CNT_W-1:0] restock_coin = '0;
    logic             fault_clr = 1'b0;
    logic             motor_on, hopper_on, busy, done, fault_jam, sold_out, change_empty;
    logic [CNT_W-1:0] prod_count, coin_count;
`ifdef PAYOUT_STATS_EN
    logic [15:0]      vend_total, coin_total;
`endif

    typedef struct packed {
        logic [CNT_W-1:0] prod;
        logic [CNT_W-1:0] coin;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    vend_payout_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dispense     (dispense),
        .return_req   (return_req),
        .prod_sensor  (prod_sensor),
        .coin_sensor  (coin_sensor),
        .restock      (restock),
        .restock_prod (restock_prod),
        .restock_coin (restock_coin),
        .fault_clr    (fault_clr),
        .motor_on     (motor_on),
        .hopper_on    (hopper_on),
        .busy         (busy),
        .done         (done),
        .fault_jam    (fault_jam),
        .sold_out     (sold_out),
        .change_empty (change_empty),
        .prod_count   (prod_count),
        .coin_count   (coin_count)
`ifdef PAYOUT_STATS_EN
        ,
        .vend_total   (vend_total),
        .coin_total   (coin_total)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restock_to(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] c);
        restock = 1'b1; restock_prod = p; restock_coin = c;
        tick();
        restock = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        total++; if (motor_on !== 1'b0) $display("FAIL reset_motor: got %b want 0", motor_on); else passed++;
        total++; if (hopper_on !== 1'b0) $display("FAIL reset_hopper: got %b want 0", hopper_on); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        total++; if (fault_jam !== 1'b0) $display("FAIL reset_jam: got %b want 0", fault_jam); else passed++;
        total++; if (sold_out !== 1'b1) $display("FAIL reset_sold_out: got %b want 1", sold_out); else passed++;
        total++; if (change_empty !== 1'b1) $display("FAIL reset_change_empty: got %b want 1", change_empty); else passed++;
        total++; if (prod_count !== 8'd0) $display("FAIL reset_prod: got %0d want 0", prod_count); else passed++;
        total++; if (coin_count !== 8'd0) $display("FAIL reset_coin: got %0d want 0", coin_count); else passed++;
        rst_n = 1'b1;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_vend();
        int   mcnt;
        int   done_at;
        logic got;
        exp_t e;
        restock_to(8'd2, 8'd1);
        total++; if (sold_out !== 1'b0) $display("FAIL vend_sold_out_after_restock: got %b want 0", sold_out); else passed++;
        sb.push_back('{prod: 8'd1, coin: 8'd1});
        dispense = 1'b1;
        tick();
        dispense = 1'b0;
        total++; if (motor_on !== 1'b0) $display("FAIL vend_motor_req_edge: got %b want 0", motor_on); else passed++;
        mcnt = 0; got = 1'b0; done_at = -1;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (done) begin
                got = 1'b1; done_at = i;
                e = sb.pop_front();
                total++; if (prod_count !== e.prod) $display("FAIL vend_prod: got %0d want %0d", prod_count, e.prod); else passed++;
                total++; if (coin_count !== e.coin) $display("FAIL vend_coin: got %0d want %0d", coin_count, e.coin); else passed++;
            end
            if (motor_on) mcnt++;
            prod_sensor = !got && (mcnt == 2);
        end
        prod_sensor = 1'b0;
        total++; if (got !== 1'b1) $display("FAIL vend_done_seen: got %b want 1", got); else passed++;
        total++; if (mcnt != 2) $display("FAIL vend_motor_cycles: got %0d want 2", mcnt); else passed++;
        total++; if (done_at != 2) $display("FAIL vend_done_latency: got %0d want 2", done_at); else passed++;
        tick();
        total++; if (done !== 1'b0) $display("FAIL vend_done_width: got %b want 0", done); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL vend_busy_end: got %b want 0", busy); else passed++;
    endtask

    task automatic test_vend_change();
        int   mcnt, hcnt, done_at;
        logic got, order_bad;
        exp_t e;
        sb.push_back('{prod: 8'd0, coin: 8'd0});
        dispense = 1'b1; return_req = 1'b1;
        tick();
        dispense = 1'b0; return_req = 1'b0;
        mcnt = 0; hcnt = 0; got = 1'b0; order_bad = 1'b0; done_at = -1;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            if (done) begin
                got = 1'b1; done_at = i;
                e = sb.pop_front();
                total++; if (prod_count !== e.prod) $display("FAIL vc_prod: got %0d want %0d", prod_count, e.prod); else passed++;
                total++; if (coin_count !== e.coin) $display("FAIL vc_coin: got %0d want %0d", coin_count, e.coin); else passed++;
            end
            if (motor_on) mcnt++;
            if (hopper_on) begin
                hcnt++;
                if (mcnt == 0) order_bad = 1'b1;
            end
            if (motor_on && hopper_on) order_bad = 1'b1;
            prod_sensor = motor_on;
            coin_sensor = hopper_on;
        end
        prod_sensor = 1'b0; coin_sensor = 1'b0;
        total++; if (got !== 1'b1) $display("FAIL vc_done_seen: got %b want 1", got); else passed++;
        total++; if (done_at != 2) $display("FAIL vc_done_latency: got %0d want 2", done_at); else passed++;
        total++; if (mcnt != 1 || hcnt != 1) $display("FAIL vc_actuations: got motor %0d hopper %0d want 1 1", mcnt, hcnt); else passed++;
        total++; if (order_bad !== 1'b0) $display("FAIL vc_order: got %b want 0", order_bad); else passed++;
        total++; if (sold_out !== 1'b1) $display("FAIL vc_sold_out: got %b want 1", sold_out); else passed++;
        total++; if (change_empty !== 1'b1) $display("FAIL vc_change_empty: got %b want 1", change_empty); else passed++;
        tick();
        total++; if (done !== 1'b0) $display("FAIL vc_single_done: got %b want 0", done); else passed++;
    endtask

    task automatic test_sold_out();
        int mcnt, dcnt;
        dispense = 1'b1;
        tick();
        dispense = 1'b0;
        mcnt = 0; dcnt = 0;
        repeat (2) begin
            tick();
            if (motor_on) mcnt++;
            if (done) dcnt++;
        end
        total++; if (busy !== 1'b0) $display("FAIL so_busy: got %b want 0", busy); else passed++;
        repeat (3) begin
            tick();
            if (motor_on) mcnt++;
            if (done) dcnt++;
        end
        total++; if (mcnt != 0) $display("FAIL so_motor: got %0d want 0", mcnt); else passed++;
        total++; if (dcnt != 0) $display("FAIL so_done: got %0d want 0", dcnt); else passed++;
        total++; if (prod_count !== 8'd0) $display("FAIL so_prod: got %0d want 0", prod_count); else passed++;
    endtask

    task automatic test_timeout();
        int   mcnt;
        logic hit;
        restock_to(8'd3, 8'd2);
        dispense = 1'b1;
        tick();
        dispense = 1'b0;
        mcnt = 0; hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (motor_on) mcnt++;
            if (fault_jam) hit = 1'b1;
        end
        total++; if (hit !== 1'b1) $display("FAIL to_jam_seen: got %b want 1", hit); else passed++;
        total++; if (mcnt != TO) $display("FAIL to_motor_cycles: got %0d want %0d", mcnt, TO); else passed++;
        total++; if (motor_on !== 1'b0) $display("FAIL to_motor_off: got %b want 0", motor_on); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL to_busy_fault: got %b want 1", busy); else passed++;
        dispense = 1'b1;
        tick();
        dispense = 1'b0;
        tick();
        total++; if (motor_on !== 1'b0) $display("FAIL to_fault_ignore_motor: got %b want 0", motor_on); else passed++;
        total++; if (fault_jam !== 1'b1) $display("FAIL to_jam_sticky: got %b want 1", fault_jam); else passed++;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        total++; if (fault_jam !== 1'b0) $display("FAIL to_jam_clear: got %b want 0", fault_jam); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL to_idle_after_clr: got %b want 0", busy); else passed++;
        mcnt = 0;
        repeat (3) begin
            tick();
            if (motor_on) mcnt++;
        end
        total++; if (mcnt != 0) $display("FAIL to_req_dropped: got %0d want 0", mcnt); else passed++;
        total++; if (prod_count !== 8'd3) $display("FAIL to_prod_kept: got %0d want 3", prod_count); else passed++;
    endtask

    task automatic test_merge();
        int   dcnt;
        exp_t e;
        sb.push_back('{prod: 8'd2, coin: 8'd2});
        dispense = 1'b1;
        tick();
        tick();
        dispense = 1'b0;
        prod_sensor = motor_on;
        dcnt = 0;
        repeat (6) begin
            tick();
            if (done) begin
                dcnt++;
                if (sb.size() == 0) begin
                    total++; $display("FAIL merge_extra_done: got done want none");
                end else begin
                    e = sb.pop_front();
                    total++; if (prod_count !== e.prod) $display("FAIL merge_prod: got %0d want %0d", prod_count, e.prod); else passed++;
                end
            end
            prod_sensor = motor_on;
        end
        prod_sensor = 1'b0;
        total++; if (dcnt != 1) $display("FAIL merge_done_count: got %0d want 1", dcnt); else passed++;
    endtask

    task automatic test_reset_mid_pay();
        return_req = 1'b1;
        tick();
        return_req = 1'b0;
        tick();
        total++; if (hopper_on !== 1'b1) $display("FAIL rst_hopper_before: got %b want 1", hopper_on); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (hopper_on !== 1'b0) $display("FAIL rst_hopper_async: got %b want 0", hopper_on); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy_async: got %b want 0", busy); else passed++;
        #2 rst_n = 1'b1;
        tick();
        total++; if (prod_count !== 8'd0) $display("FAIL rst_prod: got %0d want 0", prod_count); else passed++;
        total++; if (coin_count !== 8'd0) $display("FAIL rst_coin: got %0d want 0", coin_count); else passed++;
        tick();
        total++; if (hopper_on !== 1'b0) $display("FAIL rst_pending_lost: got %b want 0", hopper_on); else passed++;
    endtask

    task automatic test_back_to_back();
        logic got;
        exp_t e;
        restock_to(8'd5, 8'd5);
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{prod: 8'(4 - k), coin: 8'd5});
            dispense = 1'b1;
            tick();
            dispense = 1'b0;
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                tick();
                if (done) begin
                    got = 1'b1;
                    e = sb.pop_front();
                    total++; if (prod_count !== e.prod) $display("FAIL b2b_prod[%0d]: got %0d want %0d", k, prod_count, e.prod); else passed++;
                    total++; if (coin_count !== e.coin) $display("FAIL b2b_coin[%0d]: got %0d want %0d", k, coin_count, e.coin); else passed++;
                end
                prod_sensor = motor_on;
            end
            prod_sensor = 1'b0;
            total++; if (got !== 1'b1) $display("FAIL b2b_done_seen[%0d]: got %b want 1", k, got); else passed++;
        end
        total++; if (sb.size() != 0) $display("FAIL b2b_sb_left: got %0d want 0", sb.size()); else passed++;
`ifdef PAYOUT_STATS_EN
        total++; if (vend_total !== 16'd3) $display("FAIL stats_vend_total: got %0d want 3", vend_total); else passed++;
        total++; if (coin_total !== 16'd0) $display("FAIL stats_coin_total: got %0d want 0", coin_total); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_vend();
        test_vend_change();
        test_sold_out();
        test_timeout();
        test_merge();
        test_reset_mid_pay();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
